fpnew_wb_buffer: RTL and testbench

- Writeback buffer directly downstream of the FPU top-level output arbiter.
- Stores completed results (result, status, tag) in a small FIFO so the FPU pipeline is not stalled by a busy core writeback port.
- Accumulates the sticky IEEE exception flags (fflags) from every result retired to the core.
- Supports a pipeline flush that drops all buffered results.

---
 rtl/fpnew_wb_buffer.sv | 114 +++++++++++
 tb/tb_fpnew_wb_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_wb_buffer.sv
// fpnew_wb_buffer: writeback FIFO between the FPU output arbiter and the core
// writeback port. Buffers (result, status, tag), retires them in order and
// accumulates the sticky IEEE exception flags of every retired result.
// Optional build macro FPNEW_WB_FALLTHROUGH_EN: when the buffer is empty an
// incoming result is forwarded combinationally to the output (0-cycle path).
module fpnew_wb_buffer #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4,
   parameter type         TagType = logic
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic [Width-1:0]             in_result_i,
   input  logic [4:0]                   in_status_i,
   input  TagType                       in_tag_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   output logic [Width-1:0]             out_result_o,
   output logic [4:0]                   out_status_o,
   output TagType                       out_tag_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [4:0]                   fflags_o,
   input  logic                         fflags_clr_i,
   output logic [$clog2(Depth+1)-1:0]   usage_o,
   output logic                         busy_o
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW  = $clog2(Depth + 1);

   logic [Width-1:0] result_mem [Depth];
   logic [4:0]       status_mem [Depth];
   TagType           tag_mem    [Depth];

   logic [AddrW-1:0] wr_ptr;
   logic [AddrW-1:0] rd_ptr;
   logic [CntW-1:0]  count;

   logic buf_empty;
   logic fwd;
   logic pop;
   logic buf_pop;
   logic push;

   // Pointers wrap explicitly so non-power-of-two depths stay in range.
   function automatic logic [AddrW-1:0] ptr_next(input logic [AddrW-1:0] p);
      if (p == AddrW'(Depth - 1)) return '0;
      return p + AddrW'(1);
   endfunction

   assign buf_empty  = (count == '0);
   // Ready depends only on stored state, never on out_ready_i.
   assign in_ready_o = (count != CntW'(Depth));
   assign usage_o    = count;
   assign busy_o     = ~buf_empty;

`ifdef FPNEW_WB_FALLTHROUGH_EN
   // Empty buffer: present the incoming result directly.
   assign fwd          = buf_empty & in_valid_i;
   assign out_valid_o  = ~buf_empty | in_valid_i;
   assign out_result_o = fwd ? in_result_i : result_mem[rd_ptr];
   assign out_status_o = fwd ? in_status_i : status_mem[rd_ptr];
   assign out_tag_o    = fwd ? in_tag_i    : tag_mem[rd_ptr];
`else
   assign fwd          = 1'b0;
   assign out_valid_o  = ~buf_empty;
   assign out_result_o = result_mem[rd_ptr];
   assign out_status_o = status_mem[rd_ptr];
   assign out_tag_o    = tag_mem[rd_ptr];
`endif

   // A flush cancels both the retirement and the write of this cycle; a
   // forwarded result consumed this cycle is never written.
   assign pop     = out_valid_o & out_ready_i & ~flush_i;
   assign buf_pop = pop & ~fwd;
   assign push    = in_valid_i & in_ready_o & ~flush_i & ~(fwd & out_ready_i);

   // Storage write at the write pointer; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         result_mem[wr_ptr] <= in_result_i;
         status_mem[wr_ptr] <= in_status_i;
         tag_mem[wr_ptr]    <= in_tag_i;
      end
   end

   // Pointer and occupancy bookkeeping, cleared by reset or flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)    wr_ptr <= ptr_next(wr_ptr);
         if (buf_pop) rd_ptr <= ptr_next(rd_ptr);
         if (push && !buf_pop)      count <= count + CntW'(1);
         else if (!push && buf_pop) count <= count - CntW'(1);
      end
   end

   // Sticky flags gather on retirement; a clear yields to a same-cycle pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)           fflags_o <= '0;
      else if (fflags_clr_i) fflags_o <= pop ? out_status_o : 5'b0;
      else if (pop)          fflags_o <= fflags_o | out_status_o;
   end

endmodule

// File: tb/tb_fpnew_wb_buffer.sv
// Scoreboard bench for fpnew_wb_buffer: a reference FIFO (SV queue) records
// every accepted result; a monitor retires entries when the DUT handshakes.
module tb_fpnew_wb_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  st;
      logic [3:0]  tag;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        flush_i = 1'b0;
   logic [63:0] in_result_i = '0;
   logic [4:0]  in_status_i = '0;
   logic [3:0]  in_tag_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [63:0] out_result_o;
   logic [4:0]  out_status_o;
   logic [3:0]  out_tag_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [4:0]  fflags_o;
   logic        fflags_clr_i = 1'b0;
   logic [2:0]  usage_o;
   logic        busy_o;

   int   total = 0;
   int   bad = 0;
   bit   run = 1'b0;
   ent_t exp_q[$];
   logic [4:0] exp_flags = '0;
   logic [4:0] snap_flags;

   fpnew_wb_buffer #(.Width(64), .Depth(DEPTH), .TagType(logic [3:0])) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_result_i(in_result_i), .in_status_i(in_status_i), .in_tag_i(in_tag_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .out_result_o(out_result_o), .out_status_o(out_status_o), .out_tag_o(out_tag_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
      .usage_o(usage_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per-cycle status checks, then record accepted results.
   always @(negedge clk) begin
      int  sz;
      logic ov;
      if (run) begin
         sz = exp_q.size();
`ifdef FPNEW_WB_FALLTHROUGH_EN
         ov = (sz != 0) || in_valid_i;
`else
         ov = (sz != 0);
`endif
         chk("usage", 64'(usage_o), 64'(sz));
         chk("in_ready", 64'(in_ready_o), 64'(sz != DEPTH));
         chk("busy", 64'(busy_o), 64'(sz != 0));
         chk("out_valid", 64'(out_valid_o), 64'(ov));
         chk("fflags", 64'(fflags_o), 64'(exp_flags));
         if (flush_i) exp_q.delete();
         else if (in_valid_i && sz != DEPTH)
            exp_q.push_back('{res: in_result_i, st: in_status_i, tag: in_tag_i});
      end
   end

   // Monitor: retire the head on every handshake and fold its flags in.
   always @(negedge clk) begin
      ent_t e;
      logic popped;
      logic [4:0] pst;
      if (run) begin
         #1;
         popped = 1'b0;
         pst = '0;
         if (out_valid_o && out_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 64'(out_valid_o), 64'(0));
            end else begin
               e = exp_q.pop_front();
               popped = 1'b1;
               pst = e.st;
               chk("out_result", out_result_o, e.res);
               chk("out_status", 64'(out_status_o), 64'(e.st));
               chk("out_tag", 64'(out_tag_o), 64'(e.tag));
            end
         end
         if (fflags_clr_i) exp_flags = popped ? pst : 5'b0;
         else              exp_flags = exp_flags | pst;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input logic [4:0] st);
      in_result_i = {$urandom(), $urandom()};
      in_status_i = st;
      in_tag_i    = 4'($urandom());
   endtask

   // Offer one result and hold it until accepted (bounded).
   task automatic push_hold(input logic [4:0] st);
      logic acc;
      acc = 1'b0;
      set_in(st);
      in_valid_i = 1'b1;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("push_timeout", 64'(acc), 64'(1));
      in_valid_i = 1'b0;
   endtask

   initial begin
      bit done;
      #2 rst_ni = 1'b0;
      #2;
      chk("rst_usage", 64'(usage_o), 64'(0));
      chk("rst_in_ready", 64'(in_ready_o), 64'(1));
      chk("rst_out_valid", 64'(out_valid_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_fflags", 64'(fflags_o), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
      run = 1'b1;

      // In-order retirement of A, B, C with flag accumulation
      out_ready_i = 1'b1;
      push_hold(5'b00001);
      push_hold(5'b10000);
      push_hold(5'b00000);
      tick(2);
      @(negedge clk);
      chk("abc_fflags", 64'(fflags_o), 64'(5'b10001));
      tick(1);

      // Fill to capacity, fifth held upstream, then drain
      out_ready_i = 1'b0;
      repeat (4) push_hold($urandom_range(0, 31));
      @(negedge clk);
      chk("full_usage", 64'(usage_o), 64'(4));
      chk("full_in_ready", 64'(in_ready_o), 64'(0));
      tick(1);
      set_in(5'($urandom_range(0, 31)));
      in_valid_i = 1'b1;
      tick(3);
      @(negedge clk);
      chk("held_usage", 64'(usage_o), 64'(4));
      tick(1);
      out_ready_i = 1'b1;
      tick(1);
      @(negedge clk);
      chk("pop_refused_push_usage", 64'(usage_o), 64'(3));
      tick(1);
      in_valid_i = 1'b0;
      tick(6);

      // Flush with three entries held and a concurrent push
      out_ready_i = 1'b0;
      repeat (3) push_hold($urandom_range(0, 31));
      @(negedge clk);
      chk("pre_flush_usage", 64'(usage_o), 64'(3));
      tick(1);
      snap_flags = exp_flags;
      set_in(5'b11111);
      in_valid_i = 1'b1;
      flush_i = 1'b1;
      tick(1);
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid_o), 64'(0));
      chk("flush_usage", 64'(usage_o), 64'(0));
      chk("flush_busy", 64'(busy_o), 64'(0));
      chk("flush_fflags", 64'(fflags_o), 64'(snap_flags));
      tick(1);

      // Clear coinciding with a pop keeps the popped flags
      fflags_clr_i = 1'b1;
      tick(1);
      fflags_clr_i = 1'b0;
      out_ready_i = 1'b1;
      push_hold(5'b00100);
      tick(1);
      @(negedge clk);
      chk("pre_clr_fflags", 64'(fflags_o), 64'(5'b00100));
      tick(1);
      out_ready_i = 1'b0;
      push_hold(5'b01000);
      out_ready_i = 1'b1;
      fflags_clr_i = 1'b1;
      tick(1);
      fflags_clr_i = 1'b0;
      out_ready_i = 1'b0;
      @(negedge clk);
      chk("clr_pop_fflags", 64'(fflags_o), 64'(5'b01000));
      tick(1);

`ifdef FPNEW_WB_FALLTHROUGH_EN
      // Fall-through: consumed in the same cycle, or stored when stalled
      out_ready_i = 1'b1;
      set_in(5'b00010);
      in_valid_i = 1'b1;
      @(negedge clk);
      chk("ft_out_valid", 64'(out_valid_o), 64'(1));
      chk("ft_out_result", out_result_o, in_result_i);
      tick(1);
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("ft_usage0", 64'(usage_o), 64'(0));
      tick(1);
      out_ready_i = 1'b0;
      set_in(5'b00001);
      in_valid_i = 1'b1;
      tick(1);
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("ft_usage1", 64'(usage_o), 64'(1));
      tick(1);
      out_ready_i = 1'b1;
      tick(2);
`endif

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         set_in(5'($urandom_range(0, 31)));
         in_valid_i   = ($urandom_range(0, 3) != 0);
         out_ready_i  = ($urandom_range(0, 2) != 0);
         flush_i      = ($urandom_range(0, 49) == 0);
         fflags_clr_i = ($urandom_range(0, 29) == 0);
         tick(1);
      end
      in_valid_i = 1'b0;
      flush_i = 1'b0;
      fflags_clr_i = 1'b0;
      out_ready_i = 1'b1;

      // Bounded drain
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         done = !out_valid_o;
         tick(1);
      end
      if (!done) chk("drain_timeout", 64'(done), 64'(1));
      tick(2);
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
